prog_memory: RTL

PROG_MEMORY -- requirements
Module: prog_memory

---
 rtl/prog_memory.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prog_memory.sv
// Program memory with two combinational read ports (operand, fetch), a CPU write port,
// and a little-endian byte-stream loader that bulk-fills every word.
module prog_memory #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     operand_addr,
    input  logic [WORD_WIDTH-1:0] operand_wdata,
    output logic [WORD_WIDTH-1:0] operand_rdata,
    input  logic [ADDR_W-1:0]     pc_addr,
    output logic [WORD_WIDTH-1:0] pc_data,
    input  logic                  load_start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  busy,
    output logic                  load_done,
    output logic                  write_err
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    state_t                state_q,     state_d;
    logic [ADDR_W-1:0]     load_addr_q, load_addr_d;
    logic [CNT_W-1:0]      byte_cnt_q,  byte_cnt_d;
    logic [WORD_WIDTH-1:0] word_q,      word_d;
    logic                  busy_q,      busy_d;
    logic                  rx_ready_q,  rx_ready_d;
    logic                  load_done_q, load_done_d;
    logic                  write_err_q, write_err_d;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] word_asm;

    // Partial word with the incoming byte merged into its lane.
    always_comb begin
        word_asm = word_q;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
                word_asm[8*k +: 8] = rx_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_we      = 1'b0;
        mem_waddr   = operand_addr;
        mem_wdata   = operand_wdata;

        case (state_q)
            IDLE: begin
                mem_we = write;
                if (load_start) begin
                    state_d     = LOAD;
                    load_addr_d = '0;
                    byte_cnt_d  = '0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        mem_we      = 1'b1;
                        mem_waddr   = load_addr_q;
                        mem_wdata   = word_asm;
                        load_addr_d = load_addr_q + 1'b1;
                        byte_cnt_d  = '0;
                        if (load_addr_q == LAST_ADDR) begin
                            state_d = DONE;
                        end
                    end else begin
                        word_d     = word_asm;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d      = (state_d != IDLE);
        rx_ready_d  = (state_d == LOAD);
        load_done_d = (state_d == DONE);
        write_err_d = write && busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            load_addr_q <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            rx_ready_q  <= 1'b0;
            load_done_q <= 1'b0;
            write_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            rx_ready_q  <= rx_ready_d;
            load_done_q <= load_done_d;
            write_err_q <= write_err_d;
        end
    end

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign operand_rdata = mem[operand_addr];
    assign pc_data       = mem[pc_addr];
    assign rx_ready      = rx_ready_q;
    assign busy          = busy_q;
    assign load_done     = load_done_q;
    assign write_err     = write_err_q;

endmodule
